// File: rtl/keyinput_loader64_if.sv
// Serial key-load bus between the key source and the loader, plus the loaded-key outputs.
// The master drives the frame controls; the slave drives the key and status flags.
interface keyinput_loader64_if #(
    parameter int KEY_W = 64
);
    logic             key_start_i;
    logic             key_sv_i;
    logic             key_sdi_i;
    logic [KEY_W-1:0] keyinput_o;
    logic             key_valid_o;
    logic             key_busy_o;
    logic             key_err_o;
    logic             key_lockout_o;

    modport master (
        output key_start_i, key_sv_i, key_sdi_i,
        input  keyinput_o, key_valid_o, key_busy_o, key_err_o, key_lockout_o
    );

    modport slave (
        input  key_start_i, key_sv_i, key_sdi_i,
        output keyinput_o, key_valid_o, key_busy_o, key_err_o, key_lockout_o
    );
endinterface

// File: rtl/keyinput_loader64.sv
// Serial CRC-8 checked key loader for a logic-locked netlist, with permanent lockout after repeated bad frames.
// Latency: key visible the cycle after the single CHECK cycle that follows the last check bit.
// No backpressure: the source paces bits with key_sv_i, and idle cycles in SHIFT simply hold.
module keyinput_loader64 #(
    parameter int KEY_W    = 64,
    parameter int MAX_FAIL = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    keyinput_loader64_if.slave   bus
);
    localparam int CNT_W  = $clog2(KEY_W + 8);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(KEY_W + 7);
    localparam logic [CNT_W-1:0]  KEY_BITS  = CNT_W'(KEY_W);
    localparam logic [FAIL_W-1:0] LAST_FAIL = FAIL_W'(MAX_FAIL - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOADED, LOCKOUT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [KEY_W-1:0]   shift_sr;
    logic [7:0]         chk_sr;
    logic [7:0]         crc;
    logic [7:0]         crc_nxt;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [KEY_W-1:0]   key_q;
    logic               valid_q;
    logic               err_q;
    logic               clr_frame, shift_en, load_key, frame_bad;
    logic               crc_fb;

    assign crc_fb  = crc[7] ^ bus.key_sdi_i;
    assign crc_nxt = {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_frame = 1'b0;
        shift_en  = 1'b0;
        load_key  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE, LOADED: begin
                if (bus.key_start_i) begin
                    state_nxt = SHIFT;
                    clr_frame = 1'b1;
                end
            end
            SHIFT: begin
                // A start mid-frame wins over any bit presented in the same cycle.
                if (bus.key_start_i) begin
                    clr_frame = 1'b1;
                end else if (bus.key_sv_i) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (chk_sr == crc) begin
                    load_key  = 1'b1;
                    state_nxt = LOADED;
                end else begin
                    frame_bad = 1'b1;
                    state_nxt = (fail_cnt == LAST_FAIL) ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: state_nxt = LOCKOUT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt  <= '0;
            shift_sr <= '0;
            chk_sr   <= '0;
            crc      <= '0;
            fail_cnt <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= frame_bad;
            if (clr_frame) begin
                bit_cnt  <= '0;
                shift_sr <= '0;
                chk_sr   <= '0;
                crc      <= '0;
                key_q    <= '0;
                valid_q  <= 1'b0;
            end
            if (shift_en) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt < KEY_BITS) begin
                    shift_sr <= {bus.key_sdi_i, shift_sr[KEY_W-1:1]};
                    crc      <= crc_nxt;
                end else begin
                    chk_sr <= {bus.key_sdi_i, chk_sr[7:1]};
                end
            end
            if (load_key) begin
                key_q    <= shift_sr;
                valid_q  <= 1'b1;
                fail_cnt <= '0;
            end
            if (frame_bad) fail_cnt <= fail_cnt + FAIL_W'(1);
        end
    end

    assign bus.keyinput_o    = key_q;
    assign bus.key_valid_o   = valid_q;
    assign bus.key_err_o     = err_q;
    assign bus.key_busy_o    = (state == SHIFT) || (state == CHECK);
    assign bus.key_lockout_o = (state == LOCKOUT);
endmodule

// File: tb/tb_keyinput_loader64.sv
// Directed bench for keyinput_loader64: table of frames plus reset, lockout and restart sequences.
module tb_keyinput_loader64;
    localparam int KEY_W = 64;
    localparam logic [63:0] GOOD_KEY = 64'h8000_0000_0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keyinput_loader64_if #(.KEY_W(KEY_W)) bus ();

    keyinput_loader64 #(.KEY_W(KEY_W), .MAX_FAIL(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] key;
        logic [7:0]  chk;
        bit          start_sv;
        bit          gaps;
        bit          exp_ok;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [63:0] k);
        logic [7:0] c = 8'h00;
        logic       fb;
        for (int i = 0; i < KEY_W; i++) begin
            fb = c[7] ^ k[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic drive_start(input bit sv_on_start);
        @(negedge clk);
        bus.key_start_i = 1'b1;
        bus.key_sv_i    = sv_on_start;
        bus.key_sdi_i   = 1'b1;
        @(negedge clk);
        bus.key_start_i = 1'b0;
        bus.key_sv_i    = 1'b0;
    endtask

    // Returns at the negedge following acceptance of bit n-1.
    task automatic drive_bits(input logic [71:0] frame, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 7 == 3)) begin
                bus.key_sv_i  = 1'b0;
                bus.key_sdi_i = ~frame[i];
                @(negedge clk);
            end
            bus.key_sv_i  = 1'b1;
            bus.key_sdi_i = frame[i];
            @(negedge clk);
        end
        bus.key_sv_i = 1'b0;
    endtask

    // Called at the negedge where the DUT should be in CHECK.
    task automatic expect_result(input string name, input logic [63:0] exp_key, input bit exp_ok);
        check({name, " check_busy"},   64'(bus.key_busy_o),  64'd1);
        check({name, " check_key0"},   bus.keyinput_o,       64'd0);
        check({name, " check_valid0"}, 64'(bus.key_valid_o), 64'd0);
        @(negedge clk);
        check({name, " key"},   bus.keyinput_o,       exp_ok ? exp_key : 64'd0);
        check({name, " valid"}, 64'(bus.key_valid_o), 64'(exp_ok));
        check({name, " err"},   64'(bus.key_err_o),   64'(!exp_ok));
        check({name, " busy"},  64'(bus.key_busy_o),  64'd0);
        @(negedge clk);
        check({name, " err_end"}, 64'(bus.key_err_o), 64'd0);
        check({name, " key_hold"}, bus.keyinput_o, exp_ok ? exp_key : 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] k;
        bus.key_start_i = 1'b0;
        bus.key_sv_i    = 1'b0;
        bus.key_sdi_i   = 1'b0;

        vecs[0] = '{GOOD_KEY, 8'h07, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{64'd0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{64'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{GOOD_KEY, 8'h06, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{64'hC000_0000_0000_0000, 8'h09, 1'b0, 1'b1, 1'b1};
        k = 64'd1;
        vecs[5] = '{k, crc8(k), 1'b0, 1'b1, 1'b1};
        k = 64'hDEAD_BEEF_CAFE_F00D;
        vecs[6] = '{k, crc8(k), 1'b1, 1'b0, 1'b1};
        vecs[7] = '{k, crc8(k) ^ 8'h01, 1'b0, 1'b0, 1'b0};
        k = 64'h0123_4567_89AB_CDEF;
        vecs[8] = '{k, crc8(k), 1'b0, 1'b1, 1'b1};

        #1;
        check("rst key",     bus.keyinput_o,           64'd0);
        check("rst valid",   64'(bus.key_valid_o),     64'd0);
        check("rst busy",    64'(bus.key_busy_o),      64'd0);
        check("rst err",     64'(bus.key_err_o),       64'd0);
        check("rst lockout", 64'(bus.key_lockout_o),   64'd0);
        do_reset();

        foreach (vecs[v]) begin
            drive_start(vecs[v].start_sv);
            check($sformatf("vec%0d start_busy", v), 64'(bus.key_busy_o), 64'd1);
            check($sformatf("vec%0d start_key0", v), bus.keyinput_o, 64'd0);
            drive_bits({vecs[v].chk, vecs[v].key}, 72, vecs[v].gaps);
            expect_result($sformatf("vec%0d", v), vecs[v].key, vecs[v].exp_ok);
        end

        // Three consecutive bad frames lock the block out; a valid frame is then ignored.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            drive_start(1'b0);
            drive_bits({8'h01, 64'd0}, 72, 1'b0);
            expect_result($sformatf("bad%0d", f), 64'd0, 1'b0);
            check($sformatf("bad%0d lockout", f), 64'(bus.key_lockout_o), 64'(f == 2));
        end
        drive_start(1'b0);
        check("lock start_busy", 64'(bus.key_busy_o), 64'd0);
        drive_bits({8'h07, GOOD_KEY}, 72, 1'b0);
        check("lock busy",  64'(bus.key_busy_o),    64'd0);
        repeat (2) @(negedge clk);
        check("lock key",     bus.keyinput_o,         64'd0);
        check("lock valid",   64'(bus.key_valid_o),   64'd0);
        check("lock err",     64'(bus.key_err_o),     64'd0);
        check("lock lockout", 64'(bus.key_lockout_o), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("lock rst lockout", 64'(bus.key_lockout_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load, restart, abort with reset after 30 bits, then reload.
        drive_start(1'b0);
        drive_bits({8'h07, GOOD_KEY}, 72, 1'b0);
        expect_result("pre_abort", GOOD_KEY, 1'b1);
        drive_start(1'b0);
        check("abort start_key0",  bus.keyinput_o,       64'd0);
        check("abort start_valid", 64'(bus.key_valid_o), 64'd0);
        drive_bits({8'hFF, 64'hFFFF_FFFF_FFFF_FFFF}, 30, 1'b0);
        check("abort mid_busy", 64'(bus.key_busy_o), 64'd1);
        check("abort mid_key0", bus.keyinput_o,      64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort rst key",   bus.keyinput_o,       64'd0);
        check("abort rst valid", 64'(bus.key_valid_o), 64'd0);
        check("abort rst busy",  64'(bus.key_busy_o),  64'd0);
        check("abort rst err",   64'(bus.key_err_o),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(1'b0);
        drive_bits({8'h07, GOOD_KEY}, 72, 1'b0);
        expect_result("post_abort", GOOD_KEY, 1'b1);

        // Restart after 40 bits (with a bit offered on the restart cycle), then a gapped frame.
        drive_start(1'b0);
        drive_bits({8'h5A, 64'hFFFF_0000_FFFF_0000}, 40, 1'b0);
        drive_start(1'b1);
        check("restart busy", 64'(bus.key_busy_o), 64'd1);
        drive_bits({8'h07, GOOD_KEY}, 72, 1'b1);
        expect_result("restart", GOOD_KEY, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
